// File: rtl/router_ingress_queue.sv
// Ingress queue in front of the 4-way address router: buffers address-tagged
// words and issues the FIFO head only when its destination holds a credit.
module router_ingress_queue #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CREDITS    = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic [1:0]               in_addr,
    output logic [DATA_WIDTH-1:0]    din,
    output logic                     din_en,
    output logic [1:0]               addr,
    input  logic [3:0]               credit_ret,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     credit_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [2:0]  CRED_MAX   = 3'(CREDITS);

    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [1:0]            addr_mem [DEPTH];

    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           count_q;
    logic [3:0][2:0]       credit_q, credit_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] din_q;
    logic [1:0]            addr_q;
    logic                  din_en_q;

    logic                  push, issue;
    logic [1:0]            head_addr;
    logic [3:0]            issue_oh;

    // Full queue refuses input even while issuing; no pop-aware ready.
    assign in_ready  = resetn && (count_q != FULL_COUNT);
    assign push      = in_valid && in_ready;
    assign head_addr = addr_mem[rd_ptr_q];
    assign issue     = (count_q != '0) && (credit_q[head_addr] != 3'd0);
    assign issue_oh  = issue ? (4'b0001 << head_addr) : 4'b0000;

    assign din        = din_q;
    assign addr       = addr_q;
    assign din_en     = din_en_q;
    assign count      = count_q;
    assign credit_err = err_q;

    // Storage array; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= in_data;
            addr_mem[wr_ptr_q] <= in_addr;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)  wr_ptr_q <= wr_ptr_q + 1'b1;
            if (issue) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !issue) begin
                count_q <= count_q + 1'b1;
            end else if (!push && issue) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Registered router interface; zeroed in any cycle without an issue.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            din_q    <= '0;
            addr_q   <= '0;
            din_en_q <= 1'b0;
        end else if (issue) begin
            din_q    <= data_mem[rd_ptr_q];
            addr_q   <= head_addr;
            din_en_q <= 1'b1;
        end else begin
            din_q    <= '0;
            addr_q   <= '0;
            din_en_q <= 1'b0;
        end
    end

    // Per-output credit update; issue and return in one cycle cancel out.
    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        for (int i = 0; i < 4; i++) begin
            if (issue_oh[i] && !credit_ret[i]) begin
                credit_d[i] = credit_q[i] - 3'd1;
            end else if (!issue_oh[i] && credit_ret[i]) begin
                if (credit_q[i] == CRED_MAX) begin
                    err_d = 1'b1;
                end else begin
                    credit_d[i] = credit_q[i] + 3'd1;
                end
            end
        end
    end

    // Credit counters and sticky overflow flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            credit_q <= {4{CRED_MAX}};
            err_q    <= 1'b0;
        end else begin
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_router_ingress_queue.sv
// Bench for router_ingress_queue: cycle vector table plus a word scoreboard
// that checks every issued word against acceptance order.
module tb_router_ingress_queue;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [1:0]  in_addr = '0;
    logic [31:0] din;
    logic        din_en;
    logic [1:0]  addr;
    logic [3:0]  credit_ret = '0;
    logic [2:0]  count;
    logic        credit_err;

    router_ingress_queue #(
        .DATA_WIDTH (32),
        .DEPTH      (4),
        .CREDITS    (2)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_addr    (in_addr),
        .din        (din),
        .din_en     (din_en),
        .addr       (addr),
        .credit_ret (credit_ret),
        .count      (count),
        .credit_err (credit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [1:0]  a;
        logic [31:0] d;
        logic [3:0]  ret;
        logic        rdy;
        logic [2:0]  cnt;
        logic        en;
        logic [1:0]  ea;
        logic [31:0] ed;
        logic        err;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [33:0] sb[$];
    logic [33:0] exp_w;
    vec_t        tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic valid, input logic [1:0] a, input logic [31:0] d,
                               input logic [3:0] ret, input logic rdy, input logic [2:0] cnt,
                               input logic en, input logic [1:0] ea, input logic [31:0] ed,
                               input logic err);
        vec_t t;
        t.valid = valid; t.a = a; t.d = d; t.ret = ret;
        t.rdy = rdy; t.cnt = cnt; t.en = en; t.ea = ea; t.ed = ed; t.err = err;
        return t;
    endfunction

    // Drive one cycle, record any accepted word, check state after the edge.
    task automatic run_vec(input vec_t t, input string name);
        @(negedge clk);
        in_valid = t.valid; in_addr = t.a; in_data = t.d; credit_ret = t.ret;
        #1;
        if (in_valid && in_ready) sb.push_back({in_addr, in_data});
        @(posedge clk);
        #2;
        chk({name, "_ready"}, 32'(in_ready), 32'(t.rdy));
        chk({name, "_count"}, 32'(count), 32'(t.cnt));
        chk({name, "_din_en"}, 32'(din_en), 32'(t.en));
        chk({name, "_addr"}, 32'(addr), 32'(t.ea));
        chk({name, "_din"}, din, t.ed);
        chk({name, "_err"}, 32'(credit_err), 32'(t.err));
    endtask

    // Scoreboard: every issued word must be the oldest accepted one.
    always @(posedge clk) begin
        #1;
        if (din_en) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got addr %0d data %0h expected no issue", addr, din);
            end else begin
                exp_w = sb.pop_front();
                chk("sb_addr", 32'(addr), 32'(exp_w[33:32]));
                chk("sb_data", din, exp_w[31:0]);
            end
        end else begin
            chk("idle_din", din, 32'h0);
            chk("idle_addr", 32'(addr), 32'h0);
        end
    end

    always @(negedge resetn) sb.delete();

    initial begin
        // valid a  data          ret      rdy cnt en ea  expected din   err
        tbl.push_back(v(1, 2, 32'hDEADBEEF, 4'b0000, 1, 1, 0, 0, 32'h0,        0));
        tbl.push_back(v(0, 0, 32'h0,        4'b0000, 1, 0, 1, 2, 32'hDEADBEEF, 0));
        tbl.push_back(v(0, 0, 32'h0,        4'b0000, 1, 0, 0, 0, 32'h0,        0));
        tbl.push_back(v(1, 1, 32'hA0000001, 4'b0000, 1, 1, 0, 0, 32'h0,        0));
        tbl.push_back(v(1, 1, 32'hA0000002, 4'b0000, 1, 1, 1, 1, 32'hA0000001, 0));
        tbl.push_back(v(1, 1, 32'hA0000003, 4'b0000, 1, 1, 1, 1, 32'hA0000002, 0));
        tbl.push_back(v(0, 0, 32'h0,        4'b0000, 1, 1, 0, 0, 32'h0,        0));
        tbl.push_back(v(0, 0, 32'h0,        4'b0000, 1, 1, 0, 0, 32'h0,        0));
        tbl.push_back(v(0, 0, 32'h0,        4'b0010, 1, 1, 0, 0, 32'h0,        0));
        tbl.push_back(v(0, 0, 32'h0,        4'b0000, 1, 0, 1, 1, 32'hA0000003, 0));
        tbl.push_back(v(0, 0, 32'h0,        4'b0000, 1, 0, 0, 0, 32'h0,        0));
        tbl.push_back(v(1, 0, 32'hB0000000, 4'b0000, 1, 1, 0, 0, 32'h0,        0));
        tbl.push_back(v(1, 0, 32'hB0000001, 4'b0000, 1, 1, 1, 0, 32'hB0000000, 0));
        tbl.push_back(v(1, 0, 32'hB0000002, 4'b0000, 1, 1, 1, 0, 32'hB0000001, 0));
        tbl.push_back(v(1, 0, 32'hB0000003, 4'b0000, 1, 2, 0, 0, 32'h0,        0));
        tbl.push_back(v(1, 0, 32'hB0000004, 4'b0000, 1, 3, 0, 0, 32'h0,        0));
        tbl.push_back(v(1, 0, 32'hB0000005, 4'b0000, 0, 4, 0, 0, 32'h0,        0));
        tbl.push_back(v(1, 0, 32'hB0000006, 4'b0000, 0, 4, 0, 0, 32'h0,        0));
        tbl.push_back(v(1, 0, 32'hB0000006, 4'b0001, 0, 4, 0, 0, 32'h0,        0));
        tbl.push_back(v(1, 0, 32'hB0000006, 4'b0000, 1, 3, 1, 0, 32'hB0000002, 0));
        tbl.push_back(v(1, 0, 32'hB0000006, 4'b0000, 0, 4, 0, 0, 32'h0,        0));
        tbl.push_back(v(0, 0, 32'h0,        4'b0001, 0, 4, 0, 0, 32'h0,        0));
        tbl.push_back(v(0, 0, 32'h0,        4'b0001, 1, 3, 1, 0, 32'hB0000003, 0));
        tbl.push_back(v(0, 0, 32'h0,        4'b0000, 1, 2, 1, 0, 32'hB0000004, 0));
        tbl.push_back(v(0, 0, 32'h0,        4'b0000, 1, 2, 0, 0, 32'h0,        0));
        tbl.push_back(v(0, 0, 32'h0,        4'b0001, 1, 2, 0, 0, 32'h0,        0));
        tbl.push_back(v(0, 0, 32'h0,        4'b0001, 1, 1, 1, 0, 32'hB0000005, 0));
        tbl.push_back(v(0, 0, 32'h0,        4'b0001, 1, 0, 1, 0, 32'hB0000006, 0));
        tbl.push_back(v(0, 0, 32'h0,        4'b0001, 1, 0, 0, 0, 32'h0,        0));
        tbl.push_back(v(0, 0, 32'h0,        4'b0001, 1, 0, 0, 0, 32'h0,        1));
        tbl.push_back(v(0, 0, 32'h0,        4'b0000, 1, 0, 0, 0, 32'h0,        1));
        tbl.push_back(v(1, 3, 32'hC0000000, 4'b0000, 1, 1, 0, 0, 32'h0,        1));
        tbl.push_back(v(1, 3, 32'hC0000001, 4'b0000, 1, 1, 1, 3, 32'hC0000000, 1));
        tbl.push_back(v(1, 3, 32'hC0000002, 4'b0000, 1, 1, 1, 3, 32'hC0000001, 1));
        tbl.push_back(v(1, 0, 32'hD0000000, 4'b0000, 1, 2, 0, 0, 32'h0,        1));
        tbl.push_back(v(0, 0, 32'h0,        4'b0000, 1, 2, 0, 0, 32'h0,        1));
        tbl.push_back(v(0, 0, 32'h0,        4'b1000, 1, 2, 0, 0, 32'h0,        1));
        tbl.push_back(v(0, 0, 32'h0,        4'b0000, 1, 1, 1, 3, 32'hC0000002, 1));
        tbl.push_back(v(0, 0, 32'h0,        4'b0000, 1, 0, 1, 0, 32'hD0000000, 1));
        tbl.push_back(v(0, 0, 32'h0,        4'b0000, 1, 0, 0, 0, 32'h0,        1));

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_din_en", 32'(din_en), 32'h0);
        chk("rst_din", din, 32'h0);
        chk("rst_err", 32'(credit_err), 32'h0);
        resetn = 1'b1;
        #1;
        chk("rel_ready", 32'(in_ready), 32'h1);

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Mid-stream reset: head addr 3 blocked, queue builds to 3, then issues.
        run_vec(v(1, 3, 32'hF0000000, 4'b0000, 1, 1, 0, 0, 32'h0,        1), "mid0");
        run_vec(v(1, 0, 32'hF0000001, 4'b0000, 1, 2, 0, 0, 32'h0,        1), "mid1");
        run_vec(v(1, 0, 32'hF0000002, 4'b1000, 1, 3, 0, 0, 32'h0,        1), "mid2");
        run_vec(v(1, 0, 32'hF0000003, 4'b0000, 1, 3, 1, 3, 32'hF0000000, 1), "mid3");
        resetn = 1'b0;
        #1;
        chk("arst_din_en", 32'(din_en), 32'h0);
        chk("arst_din", din, 32'h0);
        chk("arst_addr", 32'(addr), 32'h0);
        chk("arst_count", 32'(count), 32'h0);
        chk("arst_ready", 32'(in_ready), 32'h0);
        chk("arst_err", 32'(credit_err), 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        credit_ret = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("arel_ready", 32'(in_ready), 32'h1);

        // Credits for output 1 (previously exhausted) are back at 2.
        run_vec(v(1, 1, 32'h60000000, 4'b0000, 1, 1, 0, 0, 32'h0,        0), "post0");
        run_vec(v(1, 1, 32'h60000001, 4'b0000, 1, 1, 1, 1, 32'h60000000, 0), "post1");
        run_vec(v(1, 1, 32'h60000002, 4'b0000, 1, 1, 1, 1, 32'h60000001, 0), "post2");
        run_vec(v(0, 0, 32'h0,        4'b0000, 1, 1, 0, 0, 32'h0,        0), "post3");
        run_vec(v(0, 0, 32'h0,        4'b0000, 1, 1, 0, 0, 32'h0,        0), "post4");

        chk("sb_left", 32'(sb.size()), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
